// File: rtl/slave_tt_timer_multi.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters behind one 16-bit slave.
// Optional per-channel timeout_pulse output when SLAVE_TT_TIMER_MULTI_PULSE_EN is defined.
module slave_tt_timer_multi #(
    parameter int NUM_CH         = 2,
    parameter int COUNT_W        = 32,
    parameter int DEFAULT_PERIOD = 49999,
    parameter int CH_AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CH_AW+2:0]  address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
`ifdef SLAVE_TT_TIMER_MULTI_PULSE_EN
    output logic [NUM_CH-1:0] timeout_pulse,
`endif
    output logic              irq
);
    localparam logic [COUNT_W-1:0] DEF  = COUNT_W'(DEFAULT_PERIOD);
    localparam int                 HI_W = COUNT_W - 16;

    typedef enum logic [2:0] {
        REG_STATUS, REG_CONTROL, REG_PERIOD_L, REG_PERIOD_H,
        REG_SNAP_L, REG_SNAP_H, REG_PRESCALE, REG_PENDING
    } reg_e;

    logic [COUNT_W-1:0] counter  [NUM_CH];
    logic [COUNT_W-1:0] period   [NUM_CH];
    logic [COUNT_W-1:0] snapshot [NUM_CH];
    logic [3:0]         control  [NUM_CH];
    logic [7:0]         prescale [NUM_CH];
    logic [7:0]         pcount   [NUM_CH];
    logic [NUM_CH-1:0]  running, timeout, zero_q, reload_q;
    logic [NUM_CH-1:0]  sel, start, stop, tick, zero, tevent, pending;
    logic               wr;
    logic [CH_AW-1:0]   a_ch;
    reg_e               a_reg;
    logic [15:0]        rd_word;

    assign wr    = chipselect & ~write_n;
    assign a_ch  = address[CH_AW+2:3];
    assign a_reg = reg_e'(address[2:0]);

    always_comb begin
        sel     = '0;
        start   = '0;
        stop    = '0;
        tick    = '0;
        zero    = '0;
        tevent  = '0;
        pending = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel[i]     = wr && (a_ch == CH_AW'(i));
            start[i]   = sel[i] && (a_reg == REG_CONTROL) && writedata[2];
            stop[i]    = sel[i] && (a_reg == REG_CONTROL) && writedata[3];
            zero[i]    = (counter[i] == '0);
            tick[i]    = running[i] && (pcount[i] == prescale[i]);
            tevent[i]  = zero[i] && !zero_q[i];
            pending[i] = timeout[i] && control[i][0];
        end
    end

    assign irq = |pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                counter[i]  <= DEF;
                period[i]   <= DEF;
                snapshot[i] <= '0;
                control[i]  <= '0;
                prescale[i] <= '0;
                pcount[i]   <= '0;
            end
            running  <= '0;
            timeout  <= '0;
            reload_q <= '0;
            zero_q   <= {NUM_CH{DEF == '0}};
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                zero_q[i]   <= zero[i];
                reload_q[i] <= sel[i] && (a_reg == REG_PERIOD_L || a_reg == REG_PERIOD_H);

                if (sel[i]) begin
                    case (a_reg)
                        REG_CONTROL:            control[i]              <= writedata[3:0];
                        REG_PERIOD_L:           period[i][15:0]         <= writedata;
                        REG_PERIOD_H:           period[i][COUNT_W-1:16] <= writedata[HI_W-1:0];
                        REG_SNAP_L, REG_SNAP_H: snapshot[i]             <= counter[i];
                        REG_PRESCALE:           prescale[i]             <= writedata[7:0];
                        default: ;
                    endcase
                end

                if (sel[i] && a_reg == REG_STATUS)
                    timeout[i] <= 1'b0;
                else if (tevent[i])
                    timeout[i] <= 1'b1;

                if (start[i])
                    running[i] <= 1'b1;
                else if (stop[i] || reload_q[i] || (running[i] && zero[i] && !control[i][1]))
                    running[i] <= 1'b0;

                // One-shot channels park at zero instead of reloading on the final tick.
                if (reload_q[i])
                    counter[i] <= period[i];
                else if (tick[i]) begin
                    if (!zero[i])
                        counter[i] <= counter[i] - 1'b1;
                    else if (control[i][1])
                        counter[i] <= period[i];
                end

                if (start[i] || reload_q[i])
                    pcount[i] <= '0;
                else if (running[i])
                    pcount[i] <= tick[i] ? 8'd0 : pcount[i] + 8'd1;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (a_ch == CH_AW'(i)) begin
                case (a_reg)
                    REG_STATUS:   rd_word = {14'd0, running[i], timeout[i]};
                    REG_CONTROL:  rd_word = {12'd0, control[i]};
                    REG_PERIOD_L: rd_word = period[i][15:0];
                    REG_PERIOD_H: rd_word = 16'(period[i][COUNT_W-1:16]);
                    REG_SNAP_L:   rd_word = snapshot[i][15:0];
                    REG_SNAP_H:   rd_word = 16'(snapshot[i][COUNT_W-1:16]);
                    REG_PRESCALE: rd_word = {8'd0, prescale[i]};
                    REG_PENDING:  rd_word = 16'(pending);
                    default:      rd_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_word;
    end

`ifdef SLAVE_TT_TIMER_MULTI_PULSE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timeout_pulse <= '0;
        else
            timeout_pulse <= tevent;
    end
`endif

endmodule

// File: tb/tb_slave_tt_timer_multi.sv
// Directed bench for slave_tt_timer_multi with four channels and default 32-bit counters.
module tb_slave_tt_timer_multi;
    localparam int NUM_CH = 4;
    localparam int CH_AW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [CH_AW+2:0] address = '0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [15:0]      writedata = '0;
    logic [15:0]      readdata;
    logic             irq;
`ifdef SLAVE_TT_TIMER_MULTI_PULSE_EN
    logic [NUM_CH-1:0] timeout_pulse;
`endif

    int tests = 0;
    int fails = 0;

    slave_tt_timer_multi #(
        .NUM_CH(NUM_CH),
        .COUNT_W(32),
        .DEFAULT_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
`ifdef SLAVE_TT_TIMER_MULTI_PULSE_EN
        .timeout_pulse(timeout_pulse),
`endif
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Bus helpers: entered at a negedge, return at the following negedge.
    task automatic bus_wr(input int ch, input int r, input logic [15:0] d);
        address    = {2'(ch), 3'(r)};
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input int ch, input int r, output logic [15:0] d);
        address = {2'(ch), 3'(r)};
        @(negedge clk);
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        int          regs [7] = '{0, 1, 2, 3, 4, 6, 7};
        logic [15:0] exp  [7] = '{16'h0, 16'h0, 16'hC34F, 16'h0, 16'h0, 16'h0, 16'h0};
        logic [15:0] d;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
        tests++;
        if (readdata !== 16'h0) begin fails++; $display("FAIL reset_readdata got %h want 0000", readdata); end
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_rd(0, regs[i], d);
            tests++;
            if (d !== exp[i]) begin fails++; $display("FAIL reset_reg%0d got %h want %h", regs[i], d, exp[i]); end
        end
        bus_rd(3, 2, d);
        tests++;
        if (d !== 16'hC34F) begin fails++; $display("FAIL reset_ch3_period got %h want c34f", d); end
    endtask

    task automatic test_reset_default;
        int          n;
        logic [15:0] d;
        bus_wr(0, 1, 16'h7);
        n = 1;
        while (irq !== 1'b1 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 50001) begin fails++; $display("FAIL default_timeout_latency got %0d want 50001", n); end
        bus_rd(0, 7, d);
        tests++;
        if (d !== 16'h1) begin fails++; $display("FAIL default_pending got %h want 0001", d); end
        bus_rd(0, 0, d);
        tests++;
        if (d !== 16'h3) begin fails++; $display("FAIL default_status got %h want 0003", d); end
        bus_wr(0, 0, 16'h0);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL default_irq_clear got %b want 0", irq); end
        bus_wr(0, 1, 16'h8);
        bus_rd(0, 0, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL default_stopped got %h want 0000", d); end
    endtask

    task automatic test_one_shot;
        logic [15:0] exp [6] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        logic [15:0] d;
        bus_wr(1, 2, 16'd4);
        bus_wr(1, 3, 16'd0);
        bus_wr(1, 1, 16'h5);
        for (int j = 1; j <= 7; j++) begin
            bus_wr(1, 4, 16'h0);
            if (j >= 2) begin
                tests++;
                if (readdata !== exp[j-2]) begin
                    fails++; $display("FAIL oneshot_count[%0d] got %0d want %0d", j-2, readdata, exp[j-2]);
                end
            end
        end
        bus_rd(1, 0, d);
        tests++;
        if (d !== 16'h1) begin fails++; $display("FAIL oneshot_status got %h want 0001", d); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq got %b want 1", irq); end
        bus_rd(1, 7, d);
        tests++;
        if (d !== 16'h2) begin fails++; $display("FAIL oneshot_pending got %h want 0002", d); end
        bus_wr(1, 4, 16'h0);
        bus_rd(1, 4, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL oneshot_hold got %0d want 0", d); end
        bus_wr(1, 0, 16'h0);
        bus_wr(1, 1, 16'h0);
    endtask

    task automatic test_prescaler;
        logic [15:0] exp [8] = '{16'd2, 16'd2, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1, 16'd1};
        int          n;
        bus_wr(0, 2, 16'd2);
        bus_wr(0, 3, 16'd0);
        bus_wr(0, 6, 16'd3);
        bus_wr(0, 1, 16'h7);
        for (int j = 1; j <= 9; j++) begin
            bus_wr(0, 4, 16'h0);
            if (j >= 2) begin
                tests++;
                if (readdata !== exp[j-2]) begin
                    fails++; $display("FAIL presc_count[%0d] got %0d want %0d", j-2, readdata, exp[j-2]);
                end
            end
            if (j == 8) begin
                tests++;
                if (irq !== 1'b0) begin fails++; $display("FAIL presc_irq_early got %b want 0", irq); end
            end
            if (j == 9) begin
                tests++;
                if (irq !== 1'b1) begin fails++; $display("FAIL presc_irq_first got %b want 1", irq); end
            end
        end
        bus_wr(0, 0, 16'h0);
        n = 11;
        while (irq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 22) begin fails++; $display("FAIL presc_event_spacing got cycle %0d want 22", n); end
        bus_wr(0, 1, 16'h8);
        bus_wr(0, 0, 16'h0);
    endtask

    task automatic test_collisions;
        logic [15:0] d;
        bus_wr(1, 2, 16'd4);
        bus_wr(1, 3, 16'd0);
        bus_wr(1, 1, 16'h5);
        idle(4);
        bus_wr(1, 0, 16'h0);
        bus_rd(1, 0, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL collide_status_clear got %h want 0000", d); end
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL collide_irq got %b want 0", irq); end
        bus_wr(1, 2, 16'd100);
        bus_wr(1, 3, 16'd0);
        bus_wr(1, 1, 16'hC);
        bus_rd(1, 0, d);
        tests++;
        if (d !== 16'h2) begin fails++; $display("FAIL collide_start_stop got %h want 0002", d); end
        bus_rd(1, 1, d);
        tests++;
        if (d !== 16'hC) begin fails++; $display("FAIL collide_control_rb got %h want 000c", d); end
        bus_wr(1, 1, 16'h8);
        bus_rd(1, 0, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL collide_stop got %h want 0000", d); end
    endtask

    task automatic test_reload;
        logic [15:0] d;
        bus_wr(2, 2, 16'd1000);
        bus_wr(2, 3, 16'd0);
        bus_wr(2, 1, 16'h6);
        idle(5);
        bus_wr(2, 2, 16'd10);
        idle(1);
        bus_rd(2, 0, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL reload_status got %h want 0000", d); end
        bus_wr(2, 4, 16'h0);
        bus_rd(2, 4, d);
        tests++;
        if (d !== 16'd10) begin fails++; $display("FAIL reload_snap_l got %0d want 10", d); end
        bus_rd(2, 5, d);
        tests++;
        if (d !== 16'd0) begin fails++; $display("FAIL reload_snap_h got %0d want 0", d); end
    endtask

    task automatic test_multi;
        logic [15:0] d;
        bus_wr(2, 2, 16'd6);
        bus_wr(3, 2, 16'd3);
        bus_wr(2, 1, 16'h5);
        bus_wr(3, 1, 16'h4);
        idle(20);
        bus_rd(3, 0, d);
        tests++;
        if (d !== 16'h1) begin fails++; $display("FAIL multi_ch3_status got %h want 0001", d); end
        bus_rd(2, 0, d);
        tests++;
        if (d !== 16'h1) begin fails++; $display("FAIL multi_ch2_status got %h want 0001", d); end
        bus_rd(0, 7, d);
        tests++;
        if (d !== 16'h4) begin fails++; $display("FAIL multi_pending_ch2 got %h want 0004", d); end
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL multi_irq_ch2 got %b want 1", irq); end
        bus_wr(2, 0, 16'h0);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL multi_irq_masked got %b want 0", irq); end
        bus_rd(3, 7, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL multi_pending_none got %h want 0000", d); end
        bus_wr(3, 1, 16'h1);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL multi_irq_ch3 got %b want 1", irq); end
        bus_rd(1, 7, d);
        tests++;
        if (d !== 16'h8) begin fails++; $display("FAIL multi_pending_ch3 got %h want 0008", d); end
        bus_wr(3, 6, 16'h5A);
        bus_rd(3, 6, d);
        tests++;
        if (d !== 16'h5A) begin fails++; $display("FAIL multi_ch3_prescale got %h want 005a", d); end
        bus_rd(2, 6, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL multi_ch2_prescale got %h want 0000", d); end
        bus_rd(3, 2, d);
        tests++;
        if (d !== 16'd3) begin fails++; $display("FAIL multi_ch3_period got %0d want 3", d); end
        bus_rd(2, 2, d);
        tests++;
        if (d !== 16'd6) begin fails++; $display("FAIL multi_ch2_period got %0d want 6", d); end
        bus_rd(3, 1, d);
        tests++;
        if (d !== 16'h1) begin fails++; $display("FAIL multi_ch3_control got %h want 0001", d); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL midreset_irq got %b want 0", irq); end
        tests++;
        if (readdata !== 16'h0) begin fails++; $display("FAIL midreset_readdata got %h want 0000", readdata); end
        @(negedge clk);
        reset = 1'b0;
        bus_rd(3, 0, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL midreset_status got %h want 0000", d); end
        bus_rd(3, 2, d);
        tests++;
        if (d !== 16'hC34F) begin fails++; $display("FAIL midreset_period got %h want c34f", d); end
        bus_rd(0, 7, d);
        tests++;
        if (d !== 16'h0) begin fails++; $display("FAIL midreset_pending got %h want 0000", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_default();
        test_one_shot();
        test_prescaler();
        test_collisions();
        test_reload();
        test_multi();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
